// File: rtl/memaccess_ctrl.sv
// memaccess_ctrl: sequences LC3 memory ops (direct, indirect, wait states) ahead of MemAccess
module memaccess_ctrl #(
   parameter int WAIT_CYCLES = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] IR_Exec,
   input  logic [15:0] Data_dout,
   output logic [1:0]  mem_state,
   output logic        M_Control,
   output logic [15:0] ind_addr,
   output logic        busy,
   output logic        done,
   output logic        start_err
);
   localparam int CW = $clog2(WAIT_CYCLES + 2);
   localparam logic [CW-1:0] CMAX = CW'(WAIT_CYCLES);
   typedef enum logic [2:0] {IDLE, RD_IND, RD, WR, DONE} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0] ms_q, ms_d;
   logic mc_q, mc_d, busy_q, busy_d, done_q, done_d, err_q, err_d, st_q, st_d;
   logic [15:0] ind_q, ind_d;
   logic [3:0] opc;
   logic last;
   logic unused_ir;
   assign opc = IR_Exec[15:12];
   assign last = cnt_q == '0;
   assign unused_ir = ^IR_Exec[11:0];
   // next-state: opcode decode in IDLE, phase countdown, indirect pointer capture
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      ind_d = ind_q;
      mc_d = mc_q;
      st_d = st_q;
      err_d = err_q | (start && state_q != IDLE);
      case (state_q)
         IDLE: if (start) begin
            cnt_d = CMAX;
            mc_d = 1'b0;
            st_d = opc[0];
            case (opc)
               4'b0010, 4'b0110: state_d = RD;
               4'b0011, 4'b0111: state_d = WR;
               4'b1010, 4'b1011: state_d = RD_IND;
               default: ;
            endcase
         end
         RD_IND: if (last) begin
            ind_d = Data_dout;
            cnt_d = CMAX;
            mc_d = 1'b1;
            state_d = st_q ? WR : RD;
         end else cnt_d = cnt_q - 1'b1;
         RD, WR: if (last) begin
            state_d = DONE;
            mc_d = 1'b0;
         end else cnt_d = cnt_q - 1'b1;
         default: state_d = IDLE;
      endcase
      ms_d = state_d == RD_IND ? 2'd1 : state_d == RD ? 2'd0 : state_d == WR ? 2'd2 : 2'd3;
      busy_d = state_d inside {RD_IND, RD, WR};
      done_d = state_d == DONE;
   end
   // all state and outputs registered; async reset aborts any access in flight
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q <= '0;
         ms_q <= 2'd3;
         mc_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         err_q <= 1'b0;
         st_q <= 1'b0;
         ind_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         ms_q <= ms_d;
         mc_q <= mc_d;
         busy_q <= busy_d;
         done_q <= done_d;
         err_q <= err_d;
         st_q <= st_d;
         ind_q <= ind_d;
      end
   end
   assign mem_state = ms_q;
   assign M_Control = mc_q;
   assign ind_addr = ind_q;
   assign busy = busy_q;
   assign done = done_q;
   assign start_err = err_q;
endmodule
